stp_rx_extract: RTL and testbench
=================================

// Module: stp_rx_extract
// PURPOSE
//  Receive-side STP extractor. Sits after the 64b/66b decoder and scans every decoded
//  66-bit block for STP messages carried in IDLE frames (INIT/ACK/BEACON).
//  Per message: checks parity, raises one-cycle receive pulses for the sync state
//  machine, and queues a timestamped record (remote counter + local arrival counter)
//  in a small FIFO for host export.
// PARAMETERS
//  FIFO_DEPTH  8   message FIFO entries; power of 2, 2..64
//  CNT_W       16  width of the saturating statistics counters
// PORTS
//  clock           in   1   core clock
//  reset           in   1   async, active-high
//  link_ok         in   1   PCS link up; low flushes the FIFO and suppresses pulses
//  clear           in   1   sync clear of the FIFO and all counters
//  decoded_datain  in   66  decoded block: [65:13] c_remote, [12] parity, [11:10] type, [9:2] block type
//  c_local         in   53  local counter, sampled as the arrival timestamp
//  init_rcvd       out  1   1-cycle pulse: good INIT received
//  ack_rcvd        out  1   1-cycle pulse: good ACK received
//  beacon_rcvd     out  1   1-cycle pulse: good BEACON received
//  c_remote        out  53  remote counter of the current good message; 0 otherwise
//  msg_valid       out  1   FIFO head valid
//  msg_ready       in   1   consumer accepts the head
//  msg_type        out  2   head type (01 INIT, 10 ACK, 11 BEACON)
//  msg_remote      out  53  head remote counter
//  msg_local       out  53  head local arrival counter
//  fifo_level      out  $clog2(FIFO_DEPTH)+1  occupancy
//  msg_cnt         out  CNT_W  good messages received (saturating)
//  parity_err_cnt  out  CNT_W  STP blocks dropped on parity (saturating)
//  overflow_cnt    out  CNT_W  good messages dropped because FIFO full (saturating)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, pointers 0.
//  - STP block: decoded_datain[9:2]==8'h1e and type!=2'b00. Type 00 is a plain IDLE and is ignored.
//  - Parity good when ^decoded_datain[65:13] == decoded_datain[12].
//  - Stage 1 (cycle N+1 for input at cycle N): register the block and c_local.
//    Good STP -> exactly one of the pulses high; c_remote = [65:13].
//    Else -> pulses 0, c_remote = 0.
//  - Bad parity STP -> no pulse, no push, parity_err_cnt+1.
//  - Push at N+1 edge. msg_valid is high at N+2 at the earliest if the FIFO was empty.
//    msg_local = c_local sampled at cycle N.
//  - Handshake: a pop occurs when msg_valid && msg_ready.
//    msg_* stay stable while msg_valid && !msg_ready.
//  - Full FIFO with a push and no pop: message dropped, overflow_cnt+1, pulses still fire.
//  - Full FIFO with push and pop in the same cycle: both happen, level unchanged.
//  - Empty FIFO with a push: no pop that cycle (no fall-through).
//  - Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
//  - Counters saturate at all-ones and never wrap.
//  - Statistics: msg_cnt+1 per good message, whether or not it was dropped.
//  - link_ok low: FIFO flushed next edge, pulses forced 0, counters hold.
//    Blocks are processed again from the first cycle link_ok is high.
//  - clear: same-edge flush of the FIFO and zeroing of all counters.
//    clear overrides a coincident push.
//  - reset mid-operation: immediate async return to the reset state; no partial record is ever emitted.
// STRUCTURE
//  - stp_pkg:
//    - constants STP_IDLE_BLK=8'h1e, STP_NONE=2'b00, STP_INIT=2'b01, STP_ACK=2'b10, STP_BEACON=2'b11
//    - typedef stp_type_t
//    - typedef struct packed {stp_type_t typ; logic[52:0] remote; logic[52:0] local_ts;} stp_msg_t
//  - One sub-module, stp_msg_fifo: synchronous FIFO of stp_msg_t with valid/ready, flush, level, full/empty.
//  - Parser, pulses and counters live in the top.
// TESTING
//  1. INIT block, c_remote=53'h1000, good parity, c_local=500
//     -> init_rcvd pulse one cycle later, c_remote=0x1000.
//     -> msg_valid next cycle with type=01, remote=0x1000, local=500.
//  2. ACK with parity bit flipped
//     -> no pulse, fifo_level stays 0, parity_err_cnt=1.
//  3. 10 back-to-back BEACONs, msg_ready=0, FIFO_DEPTH=8
//     -> 10 pulses, fifo_level=8, overflow_cnt=2, msg_cnt=10.
//     -> Drain: records 1..8 come out in order.
//  4. FIFO full, msg_ready=1 with one BEACON arriving
//     -> pop+push in the same cycle, level stays 8, overflow_cnt unchanged.
//  5. Type-00 IDLE and a non-IDLE data block (block type 8'h78)
//     -> no pulse, no push, all counters unchanged.
//  6. link_ok drops with 3 queued -> level=0 next cycle, pulses masked while low.
//     Counter stuck at 2^CNT_W-1 stays saturated.
//     reset mid-burst -> all outputs 0.

Source files
------------

// File: rtl/stp_pkg.sv
// STP message types, block constants and the queued record format shared by
// the receive extractor and its message FIFO.
package stp_pkg;

  localparam int unsigned STP_CNT_BITS = 53;
  localparam logic [7:0]  STP_IDLE_BLK = 8'h1e;

  typedef enum logic [1:0] {
    STP_NONE   = 2'b00,
    STP_INIT   = 2'b01,
    STP_ACK    = 2'b10,
    STP_BEACON = 2'b11
  } stp_type_t;

  typedef struct packed {
    stp_type_t                typ;
    logic [STP_CNT_BITS-1:0]  remote;
    logic [STP_CNT_BITS-1:0]  local_ts;
  } stp_msg_t;

  // Even parity over the remote counter field must match the parity bit.
  function automatic logic stp_parity_ok(input logic [65:0] blk);
    return (^blk[65:13]) == blk[12];
  endfunction

endpackage

// File: rtl/stp_msg_fifo.sv
// Synchronous FIFO of STP message records with valid/ready output handshake.
// Ports:
//   clock, reset      core clock, async active-high reset
//   flush             sync flush of all entries (wins over push)
//   push, push_data   write request; dropped when full unless a pop coincides
//   pop_ready         consumer accepts head when valid
//   valid, head       head-of-queue record (zero when empty)
//   level, full, empty occupancy status
module stp_msg_fifo
  import stp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  stp_msg_t                   push_data,
  input  logic                       pop_ready,
  output logic                       valid,
  output stp_msg_t                   head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  stp_msg_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign valid   = !empty;
  assign do_pop  = valid && pop_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clock) begin
    if (!flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stp_rx_extract.sv
// Receive-side STP extractor: parses decoded 66-bit blocks for STP messages
// inside IDLE frames, checks parity, pulses the sync FSM, counts statistics
// and queues timestamped records for host export.
// Ports:
//   clock, reset               core clock, async active-high reset
//   link_ok                    low flushes the queue and masks message capture
//   clear                      sync clear of queue and counters
//   decoded_datain, c_local    decoded block and local arrival counter
//   init/ack/beacon_rcvd       one-cycle pulses for a good message
//   c_remote                   remote counter of the current good message
//   msg_*                      FIFO head with valid/ready handshake
//   fifo_level                 queue occupancy
//   msg_cnt, parity_err_cnt, overflow_cnt  saturating statistics
module stp_rx_extract
  import stp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         link_ok,
  input  logic                         clear,
  input  logic [65:0]                  decoded_datain,
  input  logic [52:0]                  c_local,
  output logic                         init_rcvd,
  output logic                         ack_rcvd,
  output logic                         beacon_rcvd,
  output logic [52:0]                  c_remote,
  output logic                         msg_valid,
  input  logic                         msg_ready,
  output logic [1:0]                   msg_type,
  output logic [52:0]                  msg_remote,
  output logic [52:0]                  msg_local,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]             msg_cnt,
  output logic [CNT_W-1:0]             parity_err_cnt,
  output logic [CNT_W-1:0]             overflow_cnt
);

  stp_type_t   blk_type;
  logic        is_stp;
  logic        par_ok;
  logic        good_in;
  logic        bad_in;

  logic        s1_good;
  logic        s1_bad;
  stp_type_t   s1_type;
  logic [52:0] s1_local;

  stp_msg_t    push_rec;
  stp_msg_t    head_rec;
  logic        fifo_flush;
  logic        fifo_full;
  logic        fifo_empty;
  logic        head_pop;
  logic        drop;

  logic        unused_sync;
  assign unused_sync = ^decoded_datain[1:0];

  // Block classification; nothing is accepted while the link is down.
  assign blk_type = stp_type_t'(decoded_datain[11:10]);
  assign is_stp   = (decoded_datain[9:2] == STP_IDLE_BLK) && (blk_type != STP_NONE);
  assign par_ok   = stp_parity_ok(decoded_datain);
  assign good_in  = link_ok && is_stp && par_ok;
  assign bad_in   = link_ok && is_stp && !par_ok;

  // Stage 1: registered block decode, receive pulses and arrival timestamp.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_good     <= 1'b0;
      s1_bad      <= 1'b0;
      s1_type     <= STP_NONE;
      s1_local    <= '0;
      init_rcvd   <= 1'b0;
      ack_rcvd    <= 1'b0;
      beacon_rcvd <= 1'b0;
      c_remote    <= '0;
    end else begin
      s1_good     <= good_in;
      s1_bad      <= bad_in;
      s1_type     <= good_in ? blk_type : STP_NONE;
      s1_local    <= c_local;
      init_rcvd   <= good_in && (blk_type == STP_INIT);
      ack_rcvd    <= good_in && (blk_type == STP_ACK);
      beacon_rcvd <= good_in && (blk_type == STP_BEACON);
      c_remote    <= good_in ? decoded_datain[65:13] : '0;
    end
  end

  assign push_rec   = '{typ: s1_type, remote: c_remote, local_ts: s1_local};
  assign fifo_flush = clear || !link_ok;
  assign head_pop   = !fifo_empty && msg_ready;
  assign drop       = s1_good && fifo_full && !head_pop;

  stp_msg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (s1_good),
    .push_data (push_rec),
    .pop_ready (msg_ready),
    .valid     (msg_valid),
    .head      (head_rec),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign msg_type   = head_rec.typ;
  assign msg_remote = head_rec.remote;
  assign msg_local  = head_rec.local_ts;

  // Saturating statistics; frozen while the link is down, zeroed by clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msg_cnt        <= '0;
      parity_err_cnt <= '0;
      overflow_cnt   <= '0;
    end else if (clear) begin
      msg_cnt        <= '0;
      parity_err_cnt <= '0;
      overflow_cnt   <= '0;
    end else if (link_ok) begin
      if (s1_good && (msg_cnt != '1))
        msg_cnt <= msg_cnt + CNT_W'(1);
      if (s1_bad && (parity_err_cnt != '1))
        parity_err_cnt <= parity_err_cnt + CNT_W'(1);
      if (drop && (overflow_cnt != '1))
        overflow_cnt <= overflow_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stp_rx_extract.sv
module tb_stp_rx_extract;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        link_ok;
  logic        clear;
  logic [65:0] decoded_datain;
  logic [52:0] c_local;
  logic        init_rcvd, ack_rcvd, beacon_rcvd;
  logic [52:0] c_remote;
  logic        msg_valid;
  logic        msg_ready;
  logic [1:0]  msg_type;
  logic [52:0] msg_remote, msg_local;
  logic [3:0]  fifo_level;
  logic [CW-1:0] msg_cnt, parity_err_cnt, overflow_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  stp_rx_extract #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .link_ok        (link_ok),
    .clear          (clear),
    .decoded_datain (decoded_datain),
    .c_local        (c_local),
    .init_rcvd      (init_rcvd),
    .ack_rcvd       (ack_rcvd),
    .beacon_rcvd    (beacon_rcvd),
    .c_remote       (c_remote),
    .msg_valid      (msg_valid),
    .msg_ready      (msg_ready),
    .msg_type       (msg_type),
    .msg_remote     (msg_remote),
    .msg_local      (msg_local),
    .fifo_level     (fifo_level),
    .msg_cnt        (msg_cnt),
    .parity_err_cnt (parity_err_cnt),
    .overflow_cnt   (overflow_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [65:0] mk_blk(input logic [1:0] t, input logic [52:0] r,
                                         input logic flip);
    return {r, (^r) ^ flip, t, 8'h1e, 2'b01};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    decoded_datain = '0;
  endtask

  initial begin
    reset = 1'b1; link_ok = 1'b1; clear = 1'b0; msg_ready = 1'b0;
    decoded_datain = '0; c_local = '0;
    tick; tick;
    chk("rst_valid", 64'(msg_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_pulses", 64'({init_rcvd, ack_rcvd, beacon_rcvd}), 64'd0);
    chk("rst_cnt", 64'({msg_cnt, parity_err_cnt, overflow_cnt}), 64'd0);
    reset = 1'b0;
    tick;

    // 1: good INIT
    decoded_datain = mk_blk(2'b01, 53'h1000, 1'b0); c_local = 53'd500;
    tick;
    chk("t1_init_pulse", 64'({init_rcvd, ack_rcvd, beacon_rcvd}), 64'b100);
    chk("t1_c_remote", 64'(c_remote), 64'h1000);
    chk("t1_no_fallthrough", 64'(msg_valid), 64'd0);
    idle; c_local = 53'd501;
    tick;
    chk("t1_pulse_end", 64'(init_rcvd), 64'd0);
    chk("t1_c_remote_zero", 64'(c_remote), 64'd0);
    chk("t1_valid", 64'(msg_valid), 64'd1);
    chk("t1_type", 64'(msg_type), 64'd1);
    chk("t1_remote", 64'(msg_remote), 64'h1000);
    chk("t1_local", 64'(msg_local), 64'd500);
    chk("t1_msg_cnt", 64'(msg_cnt), 64'd1);
    msg_ready = 1'b1;
    tick;
    msg_ready = 1'b0;
    chk("t1_popped_level", 64'(fifo_level), 64'd0);
    chk("t1_popped_valid", 64'(msg_valid), 64'd0);

    // 2: ACK with bad parity
    decoded_datain = mk_blk(2'b10, 53'h2345, 1'b1);
    tick;
    chk("t2_no_pulse", 64'({init_rcvd, ack_rcvd, beacon_rcvd}), 64'd0);
    chk("t2_c_remote", 64'(c_remote), 64'd0);
    idle;
    tick;
    chk("t2_level", 64'(fifo_level), 64'd0);
    chk("t2_par_err", 64'(parity_err_cnt), 64'd1);
    chk("t2_msg_cnt", 64'(msg_cnt), 64'd1);

    // clear zeroes counters
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_cnt", 64'({msg_cnt, parity_err_cnt, overflow_cnt}), 64'd0);

    // 3: 10 back-to-back BEACONs, consumer stalled
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      decoded_datain = mk_blk(2'b11, 53'(100 + i), 1'b0); c_local = 53'(1000 + i);
      tick;
      if (beacon_rcvd === 1'b1) pulses++;
    end
    idle;
    tick;
    chk("t3_pulses", 64'(pulses), 64'd10);
    chk("t3_level_full", 64'(fifo_level), 64'd8);
    chk("t3_overflow", 64'(overflow_cnt), 64'd2);
    chk("t3_msg_cnt", 64'(msg_cnt), 64'd10);
    chk("t3_head_remote", 64'(msg_remote), 64'd100);
    tick;
    chk("t3_stable_remote", 64'(msg_remote), 64'd100);
    chk("t3_stable_local", 64'(msg_local), 64'd1000);
    chk("t3_stable_type", 64'(msg_type), 64'd3);

    // 4: full FIFO, pop and push on the same edge
    decoded_datain = mk_blk(2'b11, 53'd200, 1'b0); c_local = 53'd2000;
    tick;
    idle; msg_ready = 1'b1;
    tick;
    msg_ready = 1'b0;
    chk("t4_level", 64'(fifo_level), 64'd8);
    chk("t4_overflow", 64'(overflow_cnt), 64'd2);
    chk("t4_msg_cnt", 64'(msg_cnt), 64'd11);

    // drain in order
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 64'(msg_valid), 64'd1);
      chk("drain_remote", 64'(msg_remote), (i < 7) ? 64'(101 + i) : 64'd200);
      chk("drain_local", 64'(msg_local), (i < 7) ? 64'(1001 + i) : 64'd2000);
      msg_ready = 1'b1;
      tick;
      msg_ready = 1'b0;
    end
    chk("drain_empty", 64'(msg_valid), 64'd0);
    chk("drain_level", 64'(fifo_level), 64'd0);

    // 5: plain IDLE and a data block are ignored
    decoded_datain = mk_blk(2'b00, 53'h77, 1'b0);
    tick;
    chk("t5_idle_pulse", 64'({init_rcvd, ack_rcvd, beacon_rcvd}), 64'd0);
    decoded_datain = {53'h5, 1'b0, 2'b01, 8'h78, 2'b01};
    tick;
    chk("t5_data_pulse", 64'({init_rcvd, ack_rcvd, beacon_rcvd}), 64'd0);
    chk("t5_data_remote", 64'(c_remote), 64'd0);
    idle;
    tick;
    chk("t5_level", 64'(fifo_level), 64'd0);
    chk("t5_cnts", 64'({msg_cnt, parity_err_cnt, overflow_cnt}), 64'({4'd11, 4'd0, 4'd2}));

    // 6: link drop flushes queue and masks capture
    for (int i = 0; i < 3; i++) begin
      decoded_datain = mk_blk(2'b01, 53'(300 + i), 1'b0); c_local = 53'(3000 + i);
      tick;
    end
    idle;
    tick; tick;
    chk("t6_level3", 64'(fifo_level), 64'd3);
    link_ok = 1'b0;
    decoded_datain = mk_blk(2'b01, 53'd400, 1'b0);
    tick;
    chk("t6_flushed", 64'(fifo_level), 64'd0);
    chk("t6_masked", 64'(init_rcvd), 64'd0);
    tick;
    chk("t6_masked2", 64'(init_rcvd), 64'd0);
    chk("t6_valid", 64'(msg_valid), 64'd0);
    chk("t6_cnt_hold", 64'(msg_cnt), 64'd14);
    link_ok = 1'b1; idle;
    tick;

    // saturation of msg_cnt at 4'hf
    msg_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      decoded_datain = mk_blk(2'b11, 53'(500 + i), 1'b0);
      tick;
    end
    idle;
    tick; tick;
    chk("sat_reach", 64'(msg_cnt), 64'hf);
    decoded_datain = mk_blk(2'b10, 53'd600, 1'b0);
    tick;
    chk("sat_ack_pulse", 64'(ack_rcvd), 64'd1);
    idle;
    tick; tick;
    chk("sat_hold", 64'(msg_cnt), 64'hf);
    msg_ready = 1'b0;

    // reset mid-burst
    for (int i = 0; i < 3; i++) begin
      decoded_datain = mk_blk(2'b11, 53'(700 + i), 1'b0);
      tick;
    end
    #2 reset = 1'b1;
    #1;
    chk("mrst_pulse", 64'(beacon_rcvd), 64'd0);
    chk("mrst_remote", 64'(c_remote), 64'd0);
    chk("mrst_fifo", 64'({msg_valid, fifo_level}), 64'd0);
    chk("mrst_cnt", 64'({msg_cnt, parity_err_cnt, overflow_cnt}), 64'd0);
    chk("mrst_head", 64'({msg_type, msg_remote, msg_local}), 64'd0);
    idle;
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_valid", 64'(msg_valid), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
